// File: rtl/toggle_hs_pkg.sv
// Shared types and default sizes for the two-phase toggle handshake receiver.
// Build option: TOGGLE_RX_TIMEOUT_EN enables the HOLD timeout in toggle_hs_receiver.
package toggle_hs_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam int DEF_DATA_W      = 8;
  localparam int DEF_CNT_W       = 8;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_TIMEOUT_CYC = 255;

  // Width of a counter that must hold 0 .. cyc-1.
  function automatic int to_cnt_w(input int cyc);
    return (cyc < 2) ? 1 : $clog2(cyc);
  endfunction

endpackage

// File: rtl/toggle_sync.sv
// Synchroniser chain for the incoming request toggle plus the last-seen request level.
// A toggle is pending whenever the synchronised level differs from the last captured one.
module toggle_sync
  import toggle_hs_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic reset,
  input  logic req_tgl_i,
  input  logic capture_i,
  output logic req_s_o,
  output logic last_req_o,
  output logic toggle_det_o
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   last_req_q, last_req_d;

  always_comb begin
    sync_d     = {sync_q[SYNC_STAGES-2:0], req_tgl_i};
    last_req_d = last_req_q;
    if (capture_i) begin
      last_req_d = sync_q[SYNC_STAGES-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q     <= '0;
      last_req_q <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      last_req_q <= last_req_d;
    end
  end

  assign req_s_o      = sync_q[SYNC_STAGES-1];
  assign last_req_o   = last_req_q;
  assign toggle_det_o = sync_q[SYNC_STAGES-1] ^ last_req_q;

endmodule

// File: rtl/toggle_hs_receiver.sv
// Receiving end of a two-phase toggle handshake: each request toggle becomes one held event.
// Build option: TOGGLE_RX_TIMEOUT_EN drops a held event after TIMEOUT_CYC cycles without accept.
module toggle_hs_receiver
  import toggle_hs_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_tgl,
  input  logic [DATA_W-1:0] req_data,
  output logic              ack_tgl,
  output logic              evt_valid,
  output logic [DATA_W-1:0] evt_data,
  input  logic              evt_ready,
  output logic [CNT_W-1:0]  evt_count,
  output logic              overrun,
  output logic              timeout,
  output state_t            dbg_state
);

  // Consumer handshake: an event transfers on any rising edge where evt_valid and
  // evt_ready are both high; evt_valid and evt_data stay stable until then, and
  // evt_ready may change freely (it is ignored while nothing is held).

  state_t              state_q, state_d;
  logic                ack_q, ack_d;
  logic                valid_q, valid_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                overrun_q, overrun_d;
  logic                capture;
  logic                toggle_det;
  logic                req_s;
  logic                last_req;

  toggle_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk         (clk),
    .reset       (reset),
    .req_tgl_i   (req_tgl),
    .capture_i   (capture),
    .req_s_o     (req_s),
    .last_req_o  (last_req),
    .toggle_det_o(toggle_det)
  );

`ifdef TOGGLE_RX_TIMEOUT_EN
  localparam int TO_W = to_cnt_w(TIMEOUT_CYC);

  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            timeout_q, timeout_d;
`endif

  always_comb begin
    state_d   = state_q;
    ack_d     = ack_q;
    valid_d   = valid_q;
    data_d    = data_q;
    count_d   = count_q;
    overrun_d = overrun_q;
    capture   = 1'b0;
`ifdef TOGGLE_RX_TIMEOUT_EN
    to_cnt_d  = to_cnt_q;
    timeout_d = timeout_q;
`endif
    case (state_q)
      IDLE: begin
        if (toggle_det) begin
          capture  = 1'b1;
          data_d   = req_data;
          valid_d  = 1'b1;
          state_d  = HOLD;
`ifdef TOGGLE_RX_TIMEOUT_EN
          to_cnt_d = '0;
`endif
        end
      end
      HOLD: begin
        // A toggle seen here stays pending in the synchroniser and is taken in IDLE.
        if (toggle_det) begin
          overrun_d = 1'b1;
        end
        if (valid_q && evt_ready) begin
          valid_d = 1'b0;
          ack_d   = ~ack_q;
          count_d = count_q + CNT_W'(1);
          state_d = IDLE;
        end
`ifdef TOGGLE_RX_TIMEOUT_EN
        else if (to_cnt_q == TO_W'(TIMEOUT_CYC - 1)) begin
          valid_d   = 1'b0;
          ack_d     = ~ack_q;
          timeout_d = 1'b1;
          state_d   = IDLE;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
`endif
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      ack_q     <= 1'b0;
      valid_q   <= 1'b0;
      data_q    <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ack_q     <= ack_d;
      valid_q   <= valid_d;
      data_q    <= data_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
    end
  end

`ifdef TOGGLE_RX_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      to_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      to_cnt_q  <= to_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  // No timeout hardware; the comparison only keeps TIMEOUT_CYC referenced.
  assign timeout = (TIMEOUT_CYC < 0);
`endif

  assign ack_tgl   = ack_q;
  assign evt_valid = valid_q;
  assign evt_data  = data_q;
  assign evt_count = count_q;
  assign overrun   = overrun_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_toggle_hs_receiver.sv
// Directed bench for toggle_hs_receiver; TOGGLE_RX_TIMEOUT_EN adds the HOLD-timeout steps.
module tb_toggle_hs_receiver;
  import toggle_hs_pkg::*;

`ifdef TOGGLE_RX_TIMEOUT_EN
  localparam int TB_TO = 16;
`else
  localparam int TB_TO = 255;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req_tgl = 1'b0;
  logic [7:0] req_data = 8'h00;
  logic       ack_tgl;
  logic       evt_valid;
  logic [7:0] evt_data;
  logic       evt_ready = 1'b0;
  logic [7:0] evt_count;
  logic       overrun;
  logic       timeout;
  state_t     dbg_state;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] exp_q[$];

  toggle_hs_receiver #(
    .DATA_W     (8),
    .SYNC_STAGES(2),
    .CNT_W      (8),
    .TIMEOUT_CYC(TB_TO)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req_tgl  (req_tgl),
    .req_data (req_data),
    .ack_tgl  (ack_tgl),
    .evt_valid(evt_valid),
    .evt_data (evt_data),
    .evt_ready(evt_ready),
    .evt_count(evt_count),
    .overrun  (overrun),
    .timeout  (timeout),
    .dbg_state(dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drivers
  task automatic do_reset();
    reset     = 1'b1;
    req_tgl   = 1'b0;
    req_data  = 8'h00;
    evt_ready = 1'b0;
    tick(3);
    reset = 1'b0;
    exp_q.delete();
  endtask

  task automatic send(input logic [7:0] d);
    req_data = d;
    req_tgl  = ~req_tgl;
    exp_q.push_back(d);
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!evt_valid && n < 12) begin
      tick(1);
      n++;
    end
    chk(tag, 32'(evt_valid), 32'd1);
  endtask

  // Scoreboard: every accepted event must carry the next expected payload
  always @(negedge clk) begin
    if (!reset && evt_valid && evt_ready) begin
      if (exp_q.size() > 0) begin
        chk("sb_data", 32'(evt_data), 32'(exp_q.pop_front()));
      end else begin
        chk("sb_underflow", 32'(exp_q.size()), 32'd1);
      end
    end
  end

  initial begin
    // 1: reset state
    do_reset();
    chk("rst_valid", 32'(evt_valid), 32'd0);
    chk("rst_ack", 32'(ack_tgl), 32'd0);
    chk("rst_data", 32'(evt_data), 32'h0);
    chk("rst_count", 32'(evt_count), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(IDLE));

    // 2: single event, ready already high; valid after 3 edges, ack on the accept edge
    evt_ready = 1'b1;
    send(8'hA5);
    tick(2);
    chk("lat_edge2_valid", 32'(evt_valid), 32'd0);
    tick(1);
    chk("lat_edge3_valid", 32'(evt_valid), 32'd1);
    chk("lat_edge3_data", 32'(evt_data), 32'hA5);
    chk("lat_edge3_state", 32'(dbg_state), 32'(HOLD));
    chk("lat_edge3_ack", 32'(ack_tgl), 32'd0);
    tick(1);
    chk("acc_valid", 32'(evt_valid), 32'd0);
    chk("acc_ack", 32'(ack_tgl), 32'd1);
    chk("acc_count", 32'(evt_count), 32'd1);
    chk("acc_data_held", 32'(evt_data), 32'hA5);

    // 3: consumer stalls for 10 cycles, then a one-cycle ready pulse
    evt_ready = 1'b0;
    send(8'h5A);
    wait_valid("stall_wait");
    tick(10);
    chk("stall_valid", 32'(evt_valid), 32'd1);
    chk("stall_ack", 32'(ack_tgl), 32'd1);
    chk("stall_count", 32'(evt_count), 32'd1);
    evt_ready = 1'b1;
    tick(1);
    evt_ready = 1'b0;
    chk("pulse_valid", 32'(evt_valid), 32'd0);
    chk("pulse_ack", 32'(ack_tgl), 32'd0);
    chk("pulse_count", 32'(evt_count), 32'd2);
    tick(3);
    chk("ready_idle_count", 32'(evt_count), 32'd2);

    // 4: second toggle while held -> overrun, second event still delivered
    do_reset();
    send(8'h11);
    wait_valid("ovr_wait");
    send(8'h3C);
    tick(3);
    chk("ovr_flag", 32'(overrun), 32'd1);
    chk("ovr_data_held", 32'(evt_data), 32'h11);
    chk("ovr_count", 32'(evt_count), 32'd0);
    evt_ready = 1'b1;
    tick(1);
    chk("ovr_acc1_valid", 32'(evt_valid), 32'd0);
    chk("ovr_acc1_count", 32'(evt_count), 32'd1);
    tick(1);
    chk("ovr_second_valid", 32'(evt_valid), 32'd1);
    chk("ovr_second_data", 32'(evt_data), 32'h3C);
    tick(1);
    chk("ovr_final_count", 32'(evt_count), 32'd2);
    chk("ovr_final_ack", 32'(ack_tgl), 32'd0);
    chk("ovr_sticky", 32'(overrun), 32'd1);
    evt_ready = 1'b0;

    // 5: 256 accepted events wrap the counter
    do_reset();
    evt_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      send(8'(i * 7 + 3));
      wait_valid("wrap_wait");
      tick(1);
      if (i == 254) begin
        chk("wrap_count_ff", 32'(evt_count), 32'hFF);
        chk("wrap_ack_255", 32'(ack_tgl), 32'd1);
      end
    end
    chk("wrap_count", 32'(evt_count), 32'd0);
    chk("wrap_ack", 32'(ack_tgl), 32'd0);
    chk("wrap_overrun", 32'(overrun), 32'd0);
    evt_ready = 1'b0;

    // 6: reset while holding discards the event without an ack toggle
    do_reset();
    evt_ready = 1'b1;
    send(8'h42);
    wait_valid("rsth_wait1");
    tick(1);
    evt_ready = 1'b0;
    chk("rsth_pre_ack", 32'(ack_tgl), 32'd1);
    send(8'h99);
    wait_valid("rsth_wait2");
    reset   = 1'b1;
    req_tgl = 1'b0;
    tick(1);
    exp_q.delete();
    chk("rsth_valid", 32'(evt_valid), 32'd0);
    chk("rsth_ack", 32'(ack_tgl), 32'd0);
    chk("rsth_count", 32'(evt_count), 32'd0);
    chk("rsth_state", 32'(dbg_state), 32'(IDLE));
    reset = 1'b0;
    tick(5);
    chk("rsth_no_event", 32'(evt_valid), 32'd0);

`ifdef TOGGLE_RX_TIMEOUT_EN
    // Held event with no ready is dropped after TB_TO cycles
    send(8'h77);
    wait_valid("to_wait");
    tick(TB_TO - 1);
    chk("to_pre_valid", 32'(evt_valid), 32'd1);
    chk("to_pre_flag", 32'(timeout), 32'd0);
    tick(1);
    void'(exp_q.pop_front());
    chk("to_valid", 32'(evt_valid), 32'd0);
    chk("to_flag", 32'(timeout), 32'd1);
    chk("to_ack", 32'(ack_tgl), 32'd1);
    chk("to_count", 32'(evt_count), 32'd0);
`else
    chk("no_timeout", 32'(timeout), 32'd0);
`endif

    // Final report
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
